// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master and its clock generator.
package spi_pkg;

   typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   // Counter width that never collapses to zero bits (n=1 still needs one bit).
   function automatic int clog2_safe(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period divider: emits a tick every CLK_DIV enabled cycles, owns the sclk level
// and flags whether each toggle is a leading or trailing edge relative to the idle level.
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
)(
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic toggle_req,
   input  logic load,
   input  logic load_level,
   input  logic idle_level,
   output logic tick,
   output logic lead_edge,
   output logic trail_edge,
   output logic sclk
);

   localparam int CW = clog2_safe(CLK_DIV);

   logic [CW-1:0] cnt;
   logic          toggle;

   always_comb begin
      tick       = en && (cnt == CW'(CLK_DIV - 1));
      toggle     = tick && toggle_req;
      lead_edge  = toggle && (sclk == idle_level);
      trail_edge = toggle && (sclk != idle_level);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt  <= '0;
         sclk <= 1'b0;
      end else begin
         if (!en || tick) cnt <= '0;
         else             cnt <= cnt + 1'b1;
         if (load)        sclk <= load_level;
         else if (toggle) sclk <= ~sclk;
      end
   end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: request/done handshake on the local side, SCLK/MOSI/MISO/CS_N
// on the pin side, with configurable width, divider, bit order and CPOL/CPHA mode.
module spi_master_param
   import spi_pkg::*;
#(
   parameter int DATA_W    = 12,
   parameter int NUM_CS    = 1,
   parameter int CLK_DIV   = 4,
   parameter int MSB_FIRST = 1
)(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    new_data,
   input  logic [DATA_W-1:0]       din,
   input  logic [$clog2(NUM_CS):0] cs_sel,
   input  logic                    cpol,
   input  logic                    cpha,
   output logic                    busy,
   output logic                    done,
   output logic [DATA_W-1:0]       dout,
   output logic                    sclk,
   output logic                    mosi,
   input  logic                    miso,
   output logic [NUM_CS-1:0]       cs_n
);

   localparam int HW  = $clog2(2 * DATA_W);
   localparam int CSW = $clog2(NUM_CS) + 1;

   state_t            state;
   spi_mode_t         mode;
   logic [HW-1:0]     hcnt;
   logic [DATA_W-1:0] tx_sr, rx_sr, din_ord, rx_ord;
   logic [NUM_CS-1:0] cs_dec;
   logic              tick, lead_edge, trail_edge;
   logic              accept, en, last_half, toggle_req, cap, shift;

   always_comb begin
      din_ord = din;
      rx_ord  = rx_sr;
      // Both shift registers always run MSB-out; LSB-first is handled by mirroring at the edges.
      if (MSB_FIRST == 0) begin
         for (int unsigned i = 0; i < DATA_W; i++) begin
            din_ord[i] = din[DATA_W-1-i];
            rx_ord[i]  = rx_sr[DATA_W-1-i];
         end
      end
      cs_dec = '1;
      for (int unsigned i = 0; i < NUM_CS; i++)
         if (cs_sel == CSW'(i)) cs_dec[i] = 1'b0;
      accept     = (state == IDLE) && new_data;
      en         = (state == SETUP) || (state == XFER) || (state == HOLD);
      last_half  = (hcnt == HW'(2 * DATA_W - 1));
      // Edges fall at the start of each half-period, so the final XFER tick hands over to HOLD.
      toggle_req = (state == SETUP) || ((state == XFER) && !last_half);
      cap        = mode.cpha ? trail_edge : lead_edge;
      shift      = mode.cpha ? lead_edge  : trail_edge;
   end

   spi_clk_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_clk_gen (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (en),
      .toggle_req (toggle_req),
      .load       (accept),
      .load_level (cpol),
      .idle_level (mode.cpol),
      .tick       (tick),
      .lead_edge  (lead_edge),
      .trail_edge (trail_edge),
      .sclk       (sclk)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         mode  <= '0;
         hcnt  <= '0;
         tx_sr <= '0;
         rx_sr <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         dout  <= '0;
         mosi  <= 1'b0;
         cs_n  <= '1;
      end else begin
         done <= 1'b0;
         if (cap) rx_sr <= {rx_sr[DATA_W-2:0], miso};
         if (shift) begin
            mosi  <= tx_sr[DATA_W-1];
            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
         end
         case (state)
            IDLE: begin
               if (new_data) begin
                  state     <= SETUP;
                  mode.cpol <= cpol;
                  mode.cpha <= cpha;
                  busy      <= 1'b1;
                  cs_n      <= cs_dec;
                  hcnt      <= '0;
                  if (cpha) begin
                     tx_sr <= din_ord;
                  end else begin
                     mosi  <= din_ord[DATA_W-1];
                     tx_sr <= {din_ord[DATA_W-2:0], 1'b0};
                  end
               end
            end
            SETUP: if (tick) state <= XFER;
            XFER: begin
               if (tick) begin
                  if (last_half) state <= HOLD;
                  else           hcnt  <= hcnt + 1'b1;
               end
            end
            HOLD: begin
               if (tick) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  dout  <= rx_ord;
                  cs_n  <= '1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench for spi_master_param: two configurations, a behavioural SPI slave per
// instance, expected results queued at request time and checked when done pulses.
module tb_spi_master_param;

   localparam int LAT0 = 4 * (2 * 12 + 2) + 1;
   localparam int LAT1 = 1 * (2 * 12 + 2) + 1;

   typedef struct {
      int         inst;
      logic [11:0] exp_dout;
      logic [11:0] exp_mosi;
      int         due;
      logic [3:0] exp_cs;
      int         exp_active;
      logic       cpol;
   } exp_t;

   logic        clk, reset_n;
   logic        nd0, nd1;
   logic [11:0] din;
   logic [2:0]  cs_sel;
   logic        cpol, cpha;
   logic        busy0, done0, sclk0, mosi0, miso0;
   logic        busy1, done1, sclk1, mosi1, miso1;
   logic [11:0] dout0, dout1;
   logic [3:0]  cs_n0;
   logic [0:0]  cs_n1;

   logic [1:0]  loop, s_miso, pbusy, psclk;
   logic [1:0]  busy_v, done_v, sclk_v, mosi_v;
   logic [11:0] dout_v[2];
   logic [3:0]  cs_v[2];
   logic [1:0]  msbf;

   logic [11:0] drv_sword[2];
   logic        drv_cpol[2], drv_cpha[2];
   logic [11:0] s_word[2], s_got[2];
   logic        s_cpol[2], s_cpha[2];
   int          sk[2], rk[2], cs_active[2];
   logic [3:0]  cs_and[2];

   exp_t sb[$];
   int   cyc, vecs, errs;

   spi_master_param #(.DATA_W(12), .NUM_CS(4), .CLK_DIV(4), .MSB_FIRST(1)) u_dut (
      .clk(clk), .reset_n(reset_n), .new_data(nd0), .din(din), .cs_sel(cs_sel),
      .cpol(cpol), .cpha(cpha), .busy(busy0), .done(done0), .dout(dout0),
      .sclk(sclk0), .mosi(mosi0), .miso(miso0), .cs_n(cs_n0));

   spi_master_param #(.DATA_W(12), .NUM_CS(1), .CLK_DIV(1), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .reset_n(reset_n), .new_data(nd1), .din(din), .cs_sel(cs_sel[0:0]),
      .cpol(cpol), .cpha(cpha), .busy(busy1), .done(done1), .dout(dout1),
      .sclk(sclk1), .mosi(mosi1), .miso(miso1), .cs_n(cs_n1));

   assign miso0 = loop[0] ? mosi0 : s_miso[0];
   assign miso1 = loop[1] ? mosi1 : s_miso[1];
   assign msbf  = 2'b01;

   always_comb begin
      busy_v    = {busy1, busy0};
      done_v    = {done1, done0};
      sclk_v    = {sclk1, sclk0};
      mosi_v    = {mosi1, mosi0};
      dout_v[0] = dout0;
      dout_v[1] = dout1;
      cs_v[0]   = cs_n0;
      cs_v[1]   = {3'b111, cs_n1};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Bit k of a word in transmission order for the given bit-order setting.
   function automatic logic bitof(input logic [11:0] w, input int k, input logic m);
      return m ? w[11-k] : w[k];
   endfunction

   // Behavioural slave + scoreboard monitor, evaluated away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      logic lead;
      for (int i = 0; i < 2; i++) begin
         if (busy_v[i] && !pbusy[i]) begin
            s_word[i]    = drv_sword[i];
            s_cpol[i]    = drv_cpol[i];
            s_cpha[i]    = drv_cpha[i];
            sk[i]        = 0;
            rk[i]        = 0;
            s_got[i]     = '0;
            cs_active[i] = 0;
            cs_and[i]    = 4'hF;
            s_miso[i]    = drv_cpha[i] ? 1'b0 : bitof(drv_sword[i], 0, msbf[i]);
         end else if (sclk_v[i] != psclk[i]) begin
            lead = (sclk_v[i] != s_cpol[i]);
            if (lead ^ s_cpha[i]) begin
               if (rk[i] < 12) s_got[i][msbf[i] ? 11 - rk[i] : rk[i]] = mosi_v[i];
               rk[i]++;
            end else if (s_cpha[i]) begin
               if (sk[i] < 12) s_miso[i] = bitof(s_word[i], sk[i], msbf[i]);
               sk[i]++;
            end else begin
               sk[i]++;
               if (sk[i] < 12) s_miso[i] = bitof(s_word[i], sk[i], msbf[i]);
            end
         end
         psclk[i] = sclk_v[i];
         pbusy[i] = busy_v[i];
         if (cs_v[i] != 4'hF) cs_active[i]++;
         cs_and[i] = cs_and[i] & cs_v[i];
         if (done_v[i]) begin
            if (sb.size() == 0 || sb[0].inst != i) begin
               errs++;
               $display("FAIL done_unexpected: inst %0d got done=1, required done=0 (t=%0t)", i, $time);
            end else begin
               e = sb.pop_front();
               check("dout", dout_v[i], e.exp_dout);
               check("slave_mosi_word", s_got[i], e.exp_mosi);
               check("done_cycle", cyc, e.due);
               check("cs_pattern", cs_and[i], e.exp_cs);
               check("cs_low_cycles", cs_active[i], e.exp_active);
               check("sclk_idle", sclk_v[i], e.cpol);
               check("busy_at_done", busy_v[i], 0);
            end
         end
      end
   end

   task automatic start(input int i, input logic [11:0] d, input logic [11:0] w,
                        input logic [2:0] sel, input logic pol, input logic pha, input logic lp);
      exp_t e;
      int   lat;
      @(negedge clk);
      lat          = (i == 0) ? LAT0 : LAT1;
      din          = d;
      cs_sel       = sel;
      cpol         = pol;
      cpha         = pha;
      loop[i]      = lp;
      drv_sword[i] = w;
      drv_cpol[i]  = pol;
      drv_cpha[i]  = pha;
      e.inst       = i;
      e.exp_dout   = lp ? d : w;
      e.exp_mosi   = d;
      e.due        = cyc + lat;
      if (i == 0) e.exp_cs = (sel < 4) ? ~(4'b0001 << sel) : 4'hF;
      else        e.exp_cs = (sel == 0) ? 4'hE : 4'hF;
      e.exp_active = (e.exp_cs != 4'hF) ? lat - 1 : 0;
      e.cpol       = pol;
      sb.push_back(e);
      if (i == 0) nd0 = 1'b1; else nd1 = 1'b1;
      @(negedge clk);
      nd0 = 1'b0;
      nd1 = 1'b0;
      // Scramble the request inputs: a latched transfer must not follow them.
      din    = 12'($urandom);
      cs_sel = 3'($urandom);
      cpol   = 1'($urandom);
      cpha   = 1'($urandom);
   endtask

   task automatic drain();
      for (int n = 0; n < 400 && sb.size() != 0; n++) @(negedge clk);
      check("pending_requests", sb.size(), 0);
      sb.delete();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      vecs = 0; errs = 0;
      reset_n = 1'b0; nd0 = 1'b0; nd1 = 1'b0;
      din = '0; cs_sel = '0; cpol = 1'b0; cpha = 1'b0; loop = '0;
      for (int i = 0; i < 2; i++) begin
         drv_sword[i] = '0; drv_cpol[i] = 1'b0; drv_cpha[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_dout", dout0, 0);
      check("rst_sclk", sclk0, 0);
      check("rst_mosi", mosi0, 0);
      check("rst_cs_n", cs_n0, 4'hF);
      check("rst_dout_lsb", dout1, 0);
      check("rst_cs_n_lsb", cs_n1, 1);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Loopback, mode 0 then modes 1..3 with a fixed pattern.
      start(0, 12'd5, 12'h000, 3'd0, 1'b0, 1'b0, 1'b1);
      drain();
      for (int m = 1; m < 4; m++) begin
         start(0, 12'hA5C, 12'h000, 3'd0, 1'(m >> 1), 1'(m & 1), 1'b1);
         drain();
      end

      // Chip-select decode, including an out-of-range index.
      start(0, 12'($urandom), 12'($urandom), 3'd2, 1'b0, 1'b1, 1'b0);
      drain();
      start(0, 12'($urandom), 12'($urandom), 3'd5, 1'b1, 1'b0, 1'b0);
      drain();

      repeat (10) begin
         start(0, 12'($urandom), 12'($urandom), 3'($urandom_range(7, 0)),
               1'($urandom), 1'($urandom), 1'b0);
         drain();
      end

      // A second request mid-transfer is dropped.
      start(0, 12'h9C6, 12'h5A3, 3'd1, 1'b0, 1'b1, 1'b0);
      repeat (10) @(negedge clk);
      din = 12'h111; nd0 = 1'b1;
      @(negedge clk);
      nd0 = 1'b0;
      drain();

      // A request in the done cycle is dropped.
      start(0, 12'h2D7, 12'hB18, 3'd3, 1'b1, 1'b1, 1'b0);
      for (int n = 0; n < 300 && !done0; n++) @(negedge clk);
      din = 12'h777; nd0 = 1'b1;
      @(negedge clk);
      nd0 = 1'b0;
      repeat (3) begin
         check("busy_after_done_req", busy0, 0);
         @(negedge clk);
      end
      drain();

      // Asynchronous reset in the middle of a transfer.
      start(0, 12'h3A5, 12'h6B1, 3'd0, 1'b1, 1'b1, 1'b0);
      repeat (39) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_sclk", sclk0, 0);
      check("midrst_cs_n", cs_n0, 4'hF);
      check("midrst_busy", busy0, 0);
      check("midrst_done", done0, 0);
      if (sb.size() != 0) void'(sb.pop_back());
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      start(0, 12'h4E1, 12'h0F9, 3'd0, 1'b0, 1'b0, 1'b0);
      drain();

      // LSB-first instance with a divider of one.
      start(1, 12'hFFF, 12'h3C3, 3'd0, 1'b0, 1'b0, 1'b0);
      drain();
      start(1, 12'h001, 12'h800, 3'd0, 1'b0, 1'b0, 1'b0);
      drain();
      repeat (6) begin
         start(1, 12'($urandom), 12'($urandom), 3'($urandom_range(1, 0)),
               1'($urandom), 1'($urandom), 1'($urandom));
         drain();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at t=%0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
